// File: rtl/train_led_pkg.sv
// Shared types and constants for the train LED chain.
// Optional parity bit: define TRAIN_LED_PARITY_EN.
package train_led_pkg;

  typedef enum logic {
    RECEIVE = 1'b0,
    FORWARD = 1'b1
  } mode_t;

  localparam int SYNC_PH = 2;

`ifdef TRAIN_LED_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(
    input int nch,
    input int pwm_w
  );
    return nch * pwm_w + (PARITY_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/train_led_chain_if.sv
// Serial chain and LED bundle of one train LED node.
// master drives din, slave is the node itself.
interface train_led_chain_if #(
  parameter int NCH = 3
);

  logic           din;
  logic           dout;
  logic [NCH-1:0] led;
  logic           frame_valid;
  logic           frame_err;

  modport master (
    output din,
    input  dout,
    input  led,
    input  frame_valid,
    input  frame_err
  );

  modport slave (
    input  din,
    output dout,
    output led,
    output frame_valid,
    output frame_err
  );

endinterface

// File: rtl/train_led_pwm_ch.sv
// One PWM LED channel: duty register and comparator.
// Duty only changes at counter wrap, so no partial periods.
module train_led_pwm_ch #(
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PWM_W-1:0] duty_in,
  input  logic [PWM_W-1:0] cnt,
  output logic             led
);

  logic [PWM_W-1:0] duty;

  // latch new duty when the shared counter is at its top value
  always_ff @(posedge clk) begin
    if (rst) duty <= '0;
    else if (load) duty <= duty_in;
  end

  // registered comparator output
  always_ff @(posedge clk) begin
    if (rst) led <= 1'b0;
    else led <= (cnt < duty);
  end

endmodule

// File: rtl/train_led_chain.sv
// Train LED node: decode pulse-width frame, drive PWM LEDs, regenerate rest.
// Optional parity bit: define TRAIN_LED_PARITY_EN.
module train_led_chain
  import train_led_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int PWM_W    = 4,
  parameter int BIT_T    = 12,
  parameter int SAMPLE_T = 6,
  parameter int GAP_BITS = 8
) (
  input logic               clk,
  input logic               rst,
  train_led_chain_if.slave  bus
);

  localparam int DW      = NCH * PWM_W;
  localparam int FL      = frame_len(NCH, PWM_W);
  localparam int SR_W    = FL - 1;
  localparam int PH_W    = $clog2(BIT_T);
  localparam int GAP_LIM = GAP_BITS * BIT_T;
  localparam int GAP_W   = $clog2(GAP_LIM + 1);
  localparam int BC_W    = $clog2(FL + 1);

  localparam logic [PH_W-1:0]  PH_SYNC = PH_W'(SYNC_PH);
  localparam logic [PH_W-1:0]  PH_SAMP = PH_W'(SAMPLE_T);
  localparam logic [PH_W-1:0]  PH_FALL = PH_W'(BIT_T - 2);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(BIT_T - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LIM);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(FL - 1);
  localparam logic [PWM_W-1:0] CNT_TOP = '1;

  mode_t            mode;
  mode_t            mode_nxt;
  logic [PH_W-1:0]  ph;
  logic [GAP_W-1:0] gap;
  logic [BC_W-1:0]  bit_cnt;
  logic [SR_W-1:0]  shift_q;
  logic [FL-1:0]    capture;
  logic [DW-1:0]    frame_in;
  logic [DW-1:0]    frame;
  logic [PWM_W-1:0] cnt;
  logic [NCH-1:0]   led;
  logic             sample;
  logic             gap_hit;
  logic             last_bit;
  logic             done;
  logic             par_bad;
  logic             accept;
  logic             pending;
  logic             load;
  logic             valid_q;
  logic             dout_q;

  assign sample   = (ph == PH_SAMP);
  assign gap_hit  = (gap == GAP_MAX);
  assign last_bit = (bit_cnt == BC_LAST);
  assign capture  = {shift_q, bus.din};
  assign frame_in = capture[FL-1 -: DW];
  assign accept   = done && !par_bad;
  assign load     = pending && (cnt == CNT_TOP);

`ifdef TRAIN_LED_PARITY_EN
  logic err_q;

  // even parity over data plus parity bit must be zero
  assign par_bad = ^capture;

  // one-cycle error pulse on a bad frame
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else err_q <= done && par_bad;
  end

  assign bus.frame_err = err_q;
`else
  assign par_bad       = 1'b0;
  assign bus.frame_err = 1'b0;
`endif

  // mode register
  always_ff @(posedge clk) begin
    if (rst) mode <= RECEIVE;
    else mode <= mode_nxt;
  end

  // next mode: last bit of a frame hands over, a long gap takes back
  always_comb begin
    mode_nxt = mode;
    done     = 1'b0;
    unique case (mode)
      RECEIVE: begin
        if (!gap_hit && sample && last_bit) begin
          mode_nxt = FORWARD;
          done     = 1'b1;
        end
      end
      FORWARD: begin
        if (gap_hit) mode_nxt = RECEIVE;
      end
      default: mode_nxt = RECEIVE;
    endcase
  end

  // bit phase tracker and idle gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ph  <= '0;
      gap <= '0;
    end else begin
      if (ph < PH_SYNC) ph <= bus.din ? ph + 1'b1 : '0;
      else if (ph != PH_LAST) ph <= ph + 1'b1;
      else if (!bus.din) ph <= '0;
      if (ph > PH_SYNC) gap <= '0;
      else if (!gap_hit) gap <= gap + 1'b1;
    end
  end

  // shift in sampled bits; the final bit is taken straight from din
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (mode == RECEIVE) begin
      if (gap_hit) begin
        bit_cnt <= '0;
        shift_q <= '0;
      end else if (sample) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        if (!last_bit) shift_q <= capture[SR_W-1:0];
      end
    end
  end

  // latest good frame waits here until the next counter wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      frame   <= '0;
      pending <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        frame   <= frame_in;
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

  // regenerate clean pulses for downstream nodes
  always_ff @(posedge clk) begin
    if (rst || mode == RECEIVE) begin
      dout_q <= 1'b0;
    end else begin
      unique case (1'b1)
        ph == PH_SYNC: dout_q <= 1'b1;
        sample:        dout_q <= bus.din;
        ph == PH_FALL: dout_q <= 1'b0;
        default:       dout_q <= dout_q;
      endcase
    end
  end

  // shared free-running PWM counter
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    train_led_pwm_ch #(
      .PWM_W(PWM_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .duty_in(frame[k*PWM_W +: PWM_W]),
      .cnt    (cnt),
      .led    (led[k])
    );
  end

  assign bus.dout        = dout_q;
  assign bus.led         = led;
  assign bus.frame_valid = valid_q;

endmodule

// File: doc/train_led_chain.md
TRAIN_LED_CHAIN -- requirements
Module: train_led_chain

Interface
REQ-001 SHALL have parameter NCH, default 3, number of PWM LED channels (1..8).
REQ-002 SHALL have parameter PWM_W, default 4, duty/PWM counter width per channel (2..8).
REQ-003 SHALL have parameter BIT_T, default 12, clk cycles per serial bit slot.
REQ-004 SHALL have parameter SAMPLE_T, default 6, phase at which din is sampled; legal range is 2 < SAMPLE_T < BIT_T-2.
REQ-005 SHALL have parameter GAP_BITS, default 8, idle bit slots that constitute a chain reset.
REQ-006 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port din  input  1  serial pulse-width-coded data from upstream.
REQ-009 SHALL have port dout  output  1  regenerated serial data to downstream.
REQ-010 SHALL have port led  output  NCH  PWM outputs, bit k = channel k.
REQ-011 SHALL have port frame_valid  output  1  one-cycle pulse when a frame is accepted.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a parity failure.

Function
REQ-013 Phase counter ph: ph<2 and din=1 -> ph+1; ph<2 and din=0 -> 0; 2<=ph<BIT_T-1 -> ph+1 unconditionally; ph=BIT_T-1 -> hold while din=1, go to 0 when din=0.
REQ-014 Bit value SHALL be din sampled at ph==SAMPLE_T; the pulse-width code is long high = 1, short high = 0.
REQ-015 Mode RECEIVE: sampled bits shift into frame register; first bit received = MSB of channel NCH-1, last data bit = LSB of channel 0; dout held 0.
REQ-016 Frame length FL = NCH*PWM_W data bits (+1 parity bit when PARITY_EN); after bit FL is sampled, mode -> FORWARD in the same clock.
REQ-017 Mode FORWARD: dout<=1 at ph==2, dout<=din at ph==SAMPLE_T, dout<=0 at ph==BIT_T-2; dout is registered (1-cycle latency).
REQ-018 Gap counter: increments (saturating) while ph<=2, clears when ph>2; on reaching GAP_BITS*BIT_T -> mode RECEIVE, bit count 0, partial frame discarded.
REQ-019 On frame completion with no parity error: frame_valid pulses, a pending flag is set.
REQ-020 Each channel SHALL load its duty register from the frame only when the pending flag is set and the PWM counter == 2^PWM_W-1; the pending flag then clears (glitch-free update).
REQ-021 The PWM counter SHALL be a single shared free-running PWM_W-bit counter that wraps 2^PWM_W-1 -> 0.
REQ-022 led[k] SHALL be registered: led[k] = (counter < duty[k]); duty 0 = always off, duty 2^PWM_W-1 = on for 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-023 A new frame completing while pending is still set SHALL overwrite the frame data; only the latest frame is loaded.
REQ-024 Bits arriving in FORWARD mode SHALL NOT alter the frame register or the duty registers.

Reset
REQ-025 rst SHALL clear ph, the gap counter, bit count, frame register, duty registers, the PWM counter, the pending flag and the mode (to RECEIVE).
REQ-026 While rst is asserted and in the first cycle after it: dout=0, led=0, frame_valid=0, frame_err=0.
REQ-027 rst asserted mid-frame SHALL abort the frame; no duty register changes.

Configuration
REQ-028 With macro TRAIN_LED_PARITY_EN defined: one extra even-parity bit follows the data; on mismatch frame_err pulses, frame_valid stays 0, duty is not updated, and mode still -> FORWARD.
REQ-029 Without TRAIN_LED_PARITY_EN: FL = NCH*PWM_W and frame_err is tied to 0.

Structure
REQ-030 Package train_led_pkg SHALL hold the mode enum (RECEIVE, FORWARD), the ph-threshold constants (SYNC_PH=2) and the frame-length function.
REQ-031 The per-channel duty register and comparator SHALL be a sub-module train_led_pwm_ch, instantiated NCH times via generate.

Verification
REQ-032 Defaults, rst, then frame 0xF00 with 2-cycle '0' and 9-cycle '1' pulses -> frame_valid 1 pulse; led[2] high 15 of 16 cycles; led[1], led[0] stay 0.
REQ-033 Two back-to-back frames, 0x123 then 0x456, no gap -> first loads; the second appears on dout as 12 regenerated pulses (rise at ph 2, fall at ph 10); the duty registers are unchanged.
REQ-034 Frame, din low for 96 cycles, new frame 0x00F -> second accepted; led[0] = 15/16 duty, others off.
REQ-035 Half frame (6 bits), then din low for 96 cycles, then full frame 0x888 -> only 0x888 is loaded; each led is high 8 of 16 cycles.
REQ-036 TRAIN_LED_PARITY_EN, frame 0x001 with parity bit 0 -> frame_err pulses; led stays 0; mode is FORWARD.
REQ-037 1-cycle din glitch while idle -> ph returns to 0; no bit is sampled; bit count stays 0.
